// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M issue/sequencing controller.
//   funct3_e : RV32M funct3 encodings (MUL .. REMU)
//   state_e  : controller FSM states
//   XLEN     : operand/result width
//   DIV0_Q   : quotient returned for a divide by zero (all ones)
//   INT_MIN  : most negative signed XLEN value
package rv32m_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] DIV0_Q  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_special_case.sv
// Combinational detector for RISC-V divide corner cases that are answered
// without running the divider.
//   funct3_i : RV32M funct3 of the incoming request
//   op_a_i   : dividend (rs1)
//   op_b_i   : divisor (rs2)
//   bypass_o : 1 when the result is fully determined here
//   value_o  : architectural result when bypass_o=1, else 0
module muldiv_special_case
    import rv32m_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            bypass_o,
    output logic [XLEN-1:0] value_o
);

    logic b_zero_s;
    logic sovf_s;

    assign b_zero_s = (op_b_i == {XLEN{1'b0}});
    // Signed overflow: INT_MIN / -1
    assign sovf_s   = (op_a_i == INT_MIN) && (op_b_i == DIV0_Q);

    // Corner-case result selection; multiplies never bypass
    always_comb begin
        bypass_o = 1'b0;
        value_o  = {XLEN{1'b0}};
        case (funct3_e'(funct3_i))
            F3_DIV: begin
                if (b_zero_s) begin
                    bypass_o = 1'b1;
                    value_o  = DIV0_Q;
                end else if (sovf_s) begin
                    bypass_o = 1'b1;
                    value_o  = INT_MIN;
                end else begin
                    bypass_o = 1'b0;
                    value_o  = {XLEN{1'b0}};
                end
            end
            F3_DIVU: begin
                if (b_zero_s) begin
                    bypass_o = 1'b1;
                    value_o  = DIV0_Q;
                end else begin
                    bypass_o = 1'b0;
                    value_o  = {XLEN{1'b0}};
                end
            end
            F3_REM: begin
                if (b_zero_s) begin
                    bypass_o = 1'b1;
                    value_o  = op_a_i;
                end else if (sovf_s) begin
                    bypass_o = 1'b1;
                    value_o  = {XLEN{1'b0}};
                end else begin
                    bypass_o = 1'b0;
                    value_o  = {XLEN{1'b0}};
                end
            end
            F3_REMU: begin
                if (b_zero_s) begin
                    bypass_o = 1'b1;
                    value_o  = op_a_i;
                end else begin
                    bypass_o = 1'b0;
                    value_o  = {XLEN{1'b0}};
                end
            end
            default: begin
                bypass_o = 1'b0;
                value_o  = {XLEN{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Issue/sequencing controller for the RV32M multiplier and divider units.
// Accepts one request at a time (valid/ready), latches operands, clears and
// enables the selected unit, waits for its done (bounded by TIMEOUT RUN
// cycles) and returns the result on a valid/ready response channel.
//   clk_i/rst_i                : clock, synchronous active-high reset
//   req_*_i/o, funct3_i, op_*  : request channel
//   flush_i                    : abort in-flight operation
//   resp_*                     : response channel (err = timeout abort)
//   unit_clr_o, mul/div_en_o   : unit sequencing controls
//   unit_a/b_o, signed_*, upper_rem_o : latched operands and decoded controls
//   mul/div_result_i, done_i   : unit results and completion levels
module muldiv_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic [4:0]      resp_rd_o,
    output logic            resp_err_o,
    output logic            unit_clr_o,
    output logic            mul_en_o,
    output logic            div_en_o,
    output logic [XLEN-1:0] unit_a_o,
    output logic [XLEN-1:0] unit_b_o,
    output logic            signed_a_o,
    output logic            signed_b_o,
    output logic            upper_rem_o,
    input  logic [XLEN-1:0] mul_result_i,
    input  logic [XLEN-1:0] div_result_i,
    input  logic            mul_done_i,
    input  logic            div_done_i
);

    import rv32m_pkg::*;

    state_e            state_q, state_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic [4:0]        rd_q, rd_d;
    logic              sa_q, sa_d, sb_q, sb_d, ur_q, ur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
    logic              err_q, err_d;
    logic              clr_d;
    logic              req_ready_q, resp_valid_q, clr_q, mul_en_q, div_en_q;
    logic              accept_s, sel_done_s;
    logic              dec_sa_s, dec_sb_s, dec_ur_s;
    logic              bypass_s;
    logic [XLEN-1:0]   bypass_val_s;
    logic [XLEN-1:0]   sel_result_s;

    muldiv_special_case u_special (
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .bypass_o (bypass_s),
        .value_o  (bypass_val_s)
    );

    assign accept_s     = req_valid_i && req_ready_q;
    assign sel_done_s   = is_div_q ? div_done_i : mul_done_i;
    assign sel_result_s = is_div_q ? div_result_i : mul_result_i;
    assign cnt_inc_s    = cnt_q + CNT_W'(1);

    // Decode operand signedness and upper-half/remainder select from funct3
    always_comb begin
        dec_sa_s = 1'b0;
        dec_sb_s = 1'b0;
        dec_ur_s = 1'b0;
        case (funct3_e'(funct3_i))
            F3_MUL:    begin dec_sa_s = 1'b0; dec_sb_s = 1'b0; dec_ur_s = 1'b0; end
            F3_MULH:   begin dec_sa_s = 1'b1; dec_sb_s = 1'b1; dec_ur_s = 1'b1; end
            F3_MULHSU: begin dec_sa_s = 1'b1; dec_sb_s = 1'b0; dec_ur_s = 1'b1; end
            F3_MULHU:  begin dec_sa_s = 1'b0; dec_sb_s = 1'b0; dec_ur_s = 1'b1; end
            F3_DIV:    begin dec_sa_s = 1'b1; dec_sb_s = 1'b1; dec_ur_s = 1'b0; end
            F3_DIVU:   begin dec_sa_s = 1'b0; dec_sb_s = 1'b0; dec_ur_s = 1'b0; end
            F3_REM:    begin dec_sa_s = 1'b1; dec_sb_s = 1'b1; dec_ur_s = 1'b1; end
            F3_REMU:   begin dec_sa_s = 1'b0; dec_sb_s = 1'b0; dec_ur_s = 1'b1; end
            default:   begin dec_sa_s = 1'b0; dec_sb_s = 1'b0; dec_ur_s = 1'b0; end
        endcase
    end

    // Next-state logic: flush dominates, then per-state sequencing
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_d     = rd_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        ur_d     = ur_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        err_d    = err_q;
        clr_d    = 1'b0;
        if (flush_i && (state_q != ST_IDLE)) begin
            // Abort: clear the unit and drop any pending result
            state_d = ST_IDLE;
            clr_d   = 1'b1;
            data_d  = {XLEN{1'b0}};
            err_d   = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        is_div_d = funct3_i[2];
                        a_d      = op_a_i;
                        b_d      = op_b_i;
                        rd_d     = rd_i;
                        sa_d     = dec_sa_s;
                        sb_d     = dec_sb_s;
                        ur_d     = dec_ur_s;
                        cnt_d    = {CNT_W{1'b0}};
                        err_d    = 1'b0;
                        if (bypass_s) begin
                            // Result known at accept; the divider is never started
                            state_d = ST_RESP;
                            data_d  = bypass_val_s;
                        end else begin
                            state_d = ST_CLR;
                            clr_d   = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CLR: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    cnt_d = cnt_inc_s;
                    if (sel_done_s) begin
                        state_d = ST_RESP;
                        data_d  = sel_result_s;
                        err_d   = 1'b0;
                    end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
                        // RUN has lasted TIMEOUT cycles: abort the unit
                        state_d = ST_RESP;
                        data_d  = {XLEN{1'b0}};
                        err_d   = 1'b1;
                        clr_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        state_d = ST_IDLE;
                        data_d  = {XLEN{1'b0}};
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, latches and registered outputs (decoded from next state)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            is_div_q     <= 1'b0;
            a_q          <= {XLEN{1'b0}};
            b_q          <= {XLEN{1'b0}};
            rd_q         <= 5'd0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            ur_q         <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            data_q       <= {XLEN{1'b0}};
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            clr_q        <= 1'b0;
            mul_en_q     <= 1'b0;
            div_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_div_q     <= is_div_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rd_q         <= rd_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            ur_q         <= ur_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            err_q        <= err_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
            clr_q        <= clr_d;
            mul_en_q     <= (state_d == ST_RUN) && !is_div_d;
            div_en_q     <= (state_d == ST_RUN) && is_div_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = data_q;
    assign resp_rd_o    = rd_q;
    assign resp_err_o   = err_q;
    assign unit_clr_o   = clr_q;
    assign mul_en_o     = mul_en_q;
    assign div_en_o     = div_en_q;
    assign unit_a_o     = a_q;
    assign unit_b_o     = b_q;
    assign signed_a_o   = sa_q;
    assign signed_b_o   = sb_q;
    assign upper_rem_o  = ur_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with behavioural multiplier (7 stages) and
// divider (3 stages) models driven from the controller's unit outputs.
module tb_muldiv_ctrl;

    localparam int MUL_S = 7;
    localparam int DIV_S = 3;
    localparam int BOUND = 200;

    logic        clk = 1'b0;
    logic        rst_i, req_valid_i, req_ready_o, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i, op_b_i;
    logic [4:0]  rd_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        unit_clr_o, mul_en_o, div_en_o;
    logic [31:0] unit_a_o, unit_b_o;
    logic        signed_a_o, signed_b_o, upper_rem_o;
    logic [31:0] mul_result_i, div_result_i;
    logic        mul_done_i, div_done_i;

    logic        mul_stall, mul_done_force;
    int          mcnt, dcnt;
    int          errors, checks;
    int          lat, clr_first, clr_cnt, en_cnt;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(32), .TIMEOUT(64), .CNT_W(7)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i),
        .flush_i(flush_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o),
        .unit_clr_o(unit_clr_o), .mul_en_o(mul_en_o), .div_en_o(div_en_o),
        .unit_a_o(unit_a_o), .unit_b_o(unit_b_o), .signed_a_o(signed_a_o),
        .signed_b_o(signed_b_o), .upper_rem_o(upper_rem_o),
        .mul_result_i(mul_result_i), .div_result_i(div_result_i),
        .mul_done_i(mul_done_i), .div_done_i(div_done_i)
    );

    // Unit models: count enabled cycles since the last clear; done in the S-th one
    always @(posedge clk) begin
        if (rst_i || unit_clr_o) begin
            mcnt <= 0;
            dcnt <= 0;
        end else begin
            if (mul_en_o) mcnt <= mcnt + 1;
            if (div_en_o) dcnt <= dcnt + 1;
        end
    end

    assign mul_done_i = mul_done_force || (!mul_stall && mul_en_o && (mcnt >= MUL_S - 1));
    assign div_done_i = div_en_o && (dcnt >= DIV_S - 1);

    always_comb begin
        logic signed [63:0] pa, pb, prod;
        pa = signed_a_o ? {{32{unit_a_o[31]}}, unit_a_o} : {32'h0, unit_a_o};
        pb = signed_b_o ? {{32{unit_b_o[31]}}, unit_b_o} : {32'h0, unit_b_o};
        prod = pa * pb;
        mul_result_i = upper_rem_o ? prod[63:32] : prod[31:0];
        if (unit_b_o == 32'h0) begin
            div_result_i = 32'h0;
        end else if (signed_a_o) begin
            div_result_i = upper_rem_o ? ($signed(unit_a_o) % $signed(unit_b_o))
                                       : ($signed(unit_a_o) / $signed(unit_b_o));
        end else begin
            div_result_i = upper_rem_o ? (unit_a_o % unit_b_o) : (unit_a_o / unit_b_o);
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
        logic [2:0]  ctl;   // {signed_a, signed_b, upper_rem}
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {23'h0, req_ready_o, resp_valid_o, resp_err_o, unit_clr_o,
                            mul_en_o, div_en_o, signed_a_o, signed_b_o, upper_rem_o},
            32'h100);
        chk({tag, "_data"}, resp_data_o, 32'h0);
        chk({tag, "_rd"}, {27'h0, resp_rd_o}, 32'h0);
        chk({tag, "_a"}, unit_a_o, 32'h0);
        chk({tag, "_b"}, unit_b_o, 32'h0);
    endtask

    // Called #1 after an edge with the controller idle; returns #1 after accept edge
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        chk("req_ready_idle", {31'h0, req_ready_o}, 32'h1);
        req_valid_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b; rd_i = rd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    // Sample each cycle after accept until resp_valid_o; c=1 is the cycle after accept
    task automatic wait_resp();
        lat = -1; clr_first = 0; clr_cnt = 0; en_cnt = 0;
        for (int c = 1; c <= BOUND; c++) begin
            if (unit_clr_o) begin
                clr_cnt++;
                if (clr_first == 0) clr_first = c;
            end
            if (mul_en_o || div_en_o) en_cnt++;
            if (resp_valid_o) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic handshake();
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        chk("hs_valid_drop", {31'h0, resp_valid_o}, 32'h0);
        chk("hs_ready_back", {31'h0, req_ready_o}, 32'h1);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_i = 1'b1; req_valid_i = 1'b0; funct3_i = 3'd0; op_a_i = 32'h0; op_b_i = 32'h0;
        rd_i = 5'd0; flush_i = 1'b0; resp_ready_i = 1'b0;
        mul_stall = 1'b0; mul_done_force = 1'b0;

        // f3, a, b, rd, expected data, latency, {sa,sb,ur}
        // 0x80000001 * 0x80010002 = 0x40008001_80010002 (unsigned)
        vecs[0]  = '{3'b000, 32'h80000001, 32'h80010002, 5'd5,  32'h80010002, 9, 3'b000};
        vecs[1]  = '{3'b011, 32'h80000001, 32'h80010002, 5'd6,  32'h40008001, 9, 3'b001};
        vecs[2]  = '{3'b001, 32'h80000001, 32'h80010002, 5'd7,  32'h3FFF7FFE, 9, 3'b111};
        vecs[3]  = '{3'b010, 32'h80000001, 32'h80010002, 5'd8,  32'hBFFF7FFF, 9, 3'b101};
        vecs[4]  = '{3'b100, 32'h00000007, 32'h00000000, 5'd9,  32'hFFFFFFFF, 1, 3'b110};
        vecs[5]  = '{3'b101, 32'h00000007, 32'h00000000, 5'd10, 32'hFFFFFFFF, 1, 3'b000};
        vecs[6]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h00000000, 1, 3'b111};
        vecs[7]  = '{3'b111, 32'h00001234, 32'h00000000, 5'd12, 32'h00001234, 1, 3'b001};
        vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1, 3'b110};
        vecs[9]  = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 5, 3'b000};
        vecs[10] = '{3'b101, 32'd100,      32'd7,        5'd15, 32'd14,       5, 3'b000};
        vecs[11] = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd16, 32'hFFFFFFFF, 5, 3'b111};
        vecs[12] = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd17, 32'hFFFFFFFD, 5, 3'b110};

        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        check_reset_outputs("reset");

        // Table-driven vectors; for divides the multiplier's done is held high
        for (int i = 0; i < 13; i++) begin
            mul_done_force = vecs[i].f3[2];
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_resp();
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_data", i), resp_data_o, vecs[i].exp);
            chk($sformatf("v%0d_rd", i), {27'h0, resp_rd_o}, {27'h0, vecs[i].rd});
            chk($sformatf("v%0d_err", i), {31'h0, resp_err_o}, 32'h0);
            chk($sformatf("v%0d_ctl", i), {29'h0, signed_a_o, signed_b_o, upper_rem_o},
                {29'h0, vecs[i].ctl});
            chk($sformatf("v%0d_ops", i), unit_a_o ^ unit_b_o, vecs[i].a ^ vecs[i].b);
            if (vecs[i].lat == 1) begin
                chk($sformatf("v%0d_clr_cnt", i), 32'(clr_cnt), 32'd0);
                chk($sformatf("v%0d_en_cnt", i), 32'(en_cnt), 32'd0);
            end else begin
                chk($sformatf("v%0d_clr_at", i), 32'(clr_first), 32'd1);
                chk($sformatf("v%0d_clr_cnt", i), 32'(clr_cnt), 32'd1);
                chk($sformatf("v%0d_en_cnt", i), 32'(en_cnt), 32'(vecs[i].lat - 2));
            end
            mul_done_force = 1'b0;
            handshake();
        end

        // Backpressure: response held 3 cycles with a new request waiting
        issue(3'b000, 32'h80000001, 32'h80010002, 5'd20);
        wait_resp();
        chk("bp_lat", 32'(lat), 32'd9);
        req_valid_i = 1'b1; funct3_i = 3'b011; op_a_i = 32'h80000001;
        op_b_i = 32'h80010002; rd_i = 5'd21;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'h0, resp_valid_o}, 32'h1);
            chk("bp_data", resp_data_o, 32'h80010002);
            chk("bp_rd", {27'h0, resp_rd_o}, 32'd20);
            chk("bp_req_ready", {31'h0, req_ready_o}, 32'h0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        chk("bp_hs_ready", {31'h0, req_ready_o}, 32'h1);
        chk("bp_hs_noclr", {31'h0, unit_clr_o}, 32'h0);
        chk("bp_hs_novalid", {31'h0, resp_valid_o}, 32'h0);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("bp_acc_clr", {31'h0, unit_clr_o}, 32'h1);
        wait_resp();
        chk("bp2_lat", 32'(lat), 32'd9);
        chk("bp2_data", resp_data_o, 32'h40008001);
        chk("bp2_rd", {27'h0, resp_rd_o}, 32'd21);
        handshake();

        // flush in IDLE does nothing
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("idle_flush_clr", {31'h0, unit_clr_o}, 32'h0);
        chk("idle_flush_ready", {31'h0, req_ready_o}, 32'h1);

        // flush two cycles into RUN, then a stray mul_done must be ignored
        issue(3'b000, 32'h00000003, 32'h00000005, 5'd22);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("fl_clr", {31'h0, unit_clr_o}, 32'h1);
        chk("fl_en", {30'h0, mul_en_o, div_en_o}, 32'h0);
        chk("fl_valid", {31'h0, resp_valid_o}, 32'h0);
        chk("fl_ready", {31'h0, req_ready_o}, 32'h1);
        mul_done_force = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("fl_late_done", {30'h0, resp_valid_o, unit_clr_o}, 32'h0);
        end
        mul_done_force = 1'b0;

        // Timeout: multiplier never completes
        mul_stall = 1'b1;
        issue(3'b000, 32'h00000003, 32'h00000005, 5'd23);
        wait_resp();
        chk("to_lat", 32'(lat), 32'd66);
        chk("to_err", {31'h0, resp_err_o}, 32'h1);
        chk("to_data", resp_data_o, 32'h0);
        chk("to_rd", {27'h0, resp_rd_o}, 32'd23);
        chk("to_clr_cnt", 32'(clr_cnt), 32'd2);
        chk("to_clr_now", {31'h0, unit_clr_o}, 32'h1);
        chk("to_en_cnt", 32'(en_cnt), 32'd64);
        handshake();

        // Reset in the middle of RUN
        issue(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd24);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mr_in_run", {31'h0, mul_en_o}, 32'h1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check_reset_outputs("midrun_reset");
        mul_stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
